// File: rtl/instr_prefetch_queue_if.sv
// Bundle of the fetch-side memory port and the decode-side handshake of the
// instruction prefetch queue. "master" is the queue itself; "slave" is the
// environment (instruction memory + cpu decode) facing it.
interface instr_prefetch_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // memory instruction port
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [DATA_W-1:0] imem_data;

    // control flow change from the cpu
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // decode handshake
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;

    // occupancy
    logic [CNT_W-1:0]  count;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc,
        output count
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc,
        input  count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to instruction
// memory, buffers each returned instruction with its PC in a small circular
// FIFO, and presents the head to decode over valid/ready. A redirect flushes
// the FIFO and restarts fetch at the (word-aligned) target.
module instr_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input logic                   clk,
    input logic                   rst,
    instr_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Occupancy state kept in a register so that fetch-enable and
    // head-valid come straight from flops rather than a count compare.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_e;

    occ_e              state_q,    state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    logic push;
    logic pop;
    logic head_valid;

    // Handshake qualifiers; push depends only on registered fullness so a
    // same-cycle pop can never make room for a push when full.
    always_comb begin
        push       = rst & ~bus.redirect & (state_q != ST_FULL);
        head_valid = rst & (state_q != ST_EMPTY);
        pop        = head_valid & bus.inst_ready;
    end

    // Next-state: redirect flushes and retargets, otherwise push/pop update
    // the circular buffer, pointers, fetch PC and occupancy.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = fetch_pc_q;
                data_mem_d[wr_ptr_q] = bus.imem_data;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                fetch_pc_d           = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_W'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pc_mem_q   <= '{default: '0};
            data_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    // Output drive: head entry shown only while valid, zero when empty.
    always_comb begin
        bus.imem_addr  = fetch_pc_q;
        bus.imem_req   = push;
        bus.inst_valid = head_valid;
        bus.inst_out   = head_valid ? data_mem_q[rd_ptr_q] : '0;
        bus.inst_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : '0;
        bus.count      = count_q;
    end
endmodule
